// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back buffer in front of the single register file write port.
// Accepts writes from the ALU and the AES round unit, queues them in a small FIFO, and retires
// at most one per cycle onto addressw/writeData/writeEn.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   alu_valid/alu_addr/alu_data     ALU write request, alu_ready = accepted
//   aes_valid/aes_addr/aes_data     AES write request, aes_ready = accepted
//   wb_stall                        inhibits retirement this cycle
//   chk_addr_a, chk_addr_b, hazard  read-after-write check against pending writes
//   addressw, writeData, writeEn    registered register file write port
//   count, idle                     FIFO occupancy, nothing queued or retiring
module writeback_queue #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BITS       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [BITS-1:0] alu_data,
  output logic            alu_ready,
  input  logic            aes_valid,
  input  logic [AW-1:0]   aes_addr,
  input  logic [BITS-1:0] aes_data,
  output logic            aes_ready,
  input  logic            wb_stall,
  input  logic [AW-1:0]   chk_addr_a,
  input  logic [AW-1:0]   chk_addr_b,
  output logic            hazard,
  output logic [AW-1:0]   addressw,
  output logic [BITS-1:0] writeData,
  output logic            writeEn,
  output logic [CW-1:0]   count,
  output logic            idle
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FullCnt    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AesMaxCnt  = CW'(FIFO_DEPTH - 1);

  logic [AW-1:0]         addr_mem [FIFO_DEPTH];
  logic [BITS-1:0]       data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d, aes_slot;
  logic [CW-1:0]         count_q, count_d;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [BITS-1:0]       data_q;
  logic                  enq_alu, enq_aes, deq;
  logic                  hit_a, hit_b;

  // Modulo-FIFO_DEPTH pointer advance by 0..2; one subtraction suffices since FIFO_DEPTH >= 2.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int unsigned s;
    s = int'(p) + int'(n);
    if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
    return PW'(s);
  endfunction

  // Space is judged from the registered count only; a concurrent pop frees nothing.
  assign alu_ready = !rst && (count_q < FullCnt);
  assign aes_ready = !rst && (count_q < AesMaxCnt);

  // Register 0 is hardwired zero: such writes are handshaken and dropped.
  assign enq_alu = alu_valid && alu_ready && (alu_addr != '0);
  assign enq_aes = aes_valid && aes_ready && (aes_addr != '0);
  assign deq     = (count_q != '0) && !wb_stall;

  // The ALU entry goes ahead of the AES entry when both enqueue together.
  assign aes_slot = enq_alu ? ptr_add(wptr_q, 2'd1) : wptr_q;

  always_comb begin
    valid_d = valid_q;
    if (deq)     valid_d[rptr_q]   = 1'b0;
    if (enq_alu) valid_d[wptr_q]   = 1'b1;
    if (enq_aes) valid_d[aes_slot] = 1'b1;
    rptr_d  = ptr_add(rptr_q, {1'b0, deq});
    wptr_d  = ptr_add(wptr_q, {1'b0, enq_alu} + {1'b0, enq_aes});
    count_d = count_q + CW'(enq_alu) + CW'(enq_aes) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      valid_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      valid_q <= valid_d;
      we_q    <= deq;
      if (deq) begin
        addr_q <= addr_mem[rptr_q];
        data_q <= data_mem[rptr_q];
      end
    end
  end

  // Storage needs no reset: valid_q qualifies every slot.
  always_ff @(posedge clk) begin
    if (enq_alu) begin
      addr_mem[wptr_q] <= alu_addr;
      data_mem[wptr_q] <= alu_data;
    end
    if (enq_aes) begin
      addr_mem[aes_slot] <= aes_addr;
      data_mem[aes_slot] <= aes_data;
    end
  end

  // Hazard covers queued entries plus the write currently on the port, not this cycle's requests.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (valid_q[i] && (addr_mem[i] == chk_addr_a)) hit_a = 1'b1;
      if (valid_q[i] && (addr_mem[i] == chk_addr_b)) hit_b = 1'b1;
    end
    if (we_q && (addr_q == chk_addr_a)) hit_a = 1'b1;
    if (we_q && (addr_q == chk_addr_b)) hit_b = 1'b1;
    hazard = (hit_a && (chk_addr_a != '0)) || (hit_b && (chk_addr_b != '0));
  end

  assign addressw  = addr_q;
  assign writeData = data_q;
  assign writeEn   = we_q;
  assign count     = count_q;
  assign idle      = (count_q == '0) && !we_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: a cycle model with a scoreboard queue of pending writes checks
// ready, count, hazard, idle and the write port every cycle across directed scenarios.
module tb_writeback_queue;

  localparam int FD = 4;
  localparam int AW = 4;
  localparam int BW = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, aes_valid = 1'b0, wb_stall = 1'b0;
  logic [AW-1:0] alu_addr = '0, aes_addr = '0, chk_addr_a = '0, chk_addr_b = '0;
  logic [BW-1:0] alu_data = '0, aes_data = '0;
  logic          alu_ready, aes_ready, hazard, writeEn, idle;
  logic [AW-1:0] addressw;
  logic [BW-1:0] writeData;
  logic [2:0]    count;

  writeback_queue #(.DEPTH(16), .BITS(BW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .aes_valid(aes_valid), .aes_addr(aes_addr), .aes_data(aes_data), .aes_ready(aes_ready),
    .wb_stall(wb_stall), .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .hazard(hazard),
    .addressw(addressw), .writeData(writeData), .writeEn(writeEn), .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  entry_t        mq[$];
  int            mc = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_data = '0;
  bit            aa, ab;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hz_model();
    bit h = 1'b0;
    foreach (mq[i]) begin
      if (chk_addr_a != 0 && mq[i].a == chk_addr_a) h = 1'b1;
      if (chk_addr_b != 0 && mq[i].a == chk_addr_b) h = 1'b1;
    end
    if (m_we && chk_addr_a != 0 && m_addr == chk_addr_a) h = 1'b1;
    if (m_we && chk_addr_b != 0 && m_addr == chk_addr_b) h = 1'b1;
    return h;
  endfunction

  // Called at a negedge with inputs already driven; checks outputs, then advances one cycle.
  task automatic tick(output bit acc_a, output bit acc_b);
    bit     era, ebr, deq;
    entry_t e;
    #1;
    era = !rst && (mc < FD);
    ebr = !rst && (mc < FD - 1);
    chk("alu_ready", alu_ready, era);
    chk("aes_ready", aes_ready, ebr);
    chk("count", count, mc);
    chk("count_bound", count <= FD, 1);
    chk("writeEn", writeEn, m_we);
    chk("addressw", addressw, m_addr);
    chk("writeData", writeData, m_data);
    chk("idle", idle, (mc == 0) && !m_we);
    chk("hazard", hazard, hz_model());
    acc_a = alu_valid && era;
    acc_b = aes_valid && ebr;
    deq   = !rst && (mc > 0) && !wb_stall;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      if (deq) begin
        e = mq.pop_front();
        m_we = 1'b1;
        m_addr = e.a;
        m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (acc_a && alu_addr != 0) mq.push_back('{alu_addr, alu_data});
      if (acc_b && aes_addr != 0) mq.push_back('{aes_addr, aes_data});
    end
    mc = mq.size();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(aa, ab);
  endtask

  int n_acc;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h1;
    tick(aa, ab);
    alu_valid = 1'b0;
    rst = 1'b0;
    ticks(1);

    // Single write to r5, hazard tracked on chk_addr_a
    chk_addr_a = 4'd5; chk_addr_b = 4'd9;
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'hDEADBEEF;
    tick(aa, ab);
    alu_valid = 1'b0;
    ticks(4);

    // Simultaneous producers to r3: ALU first
    chk_addr_a = 4'd0; chk_addr_b = 4'd3;
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
    aes_valid = 1'b1; aes_addr = 4'd3; aes_data = 32'h22;
    tick(aa, ab);
    alu_valid = 1'b0; aes_valid = 1'b0;
    ticks(5);

    // Backpressure: stall, ALU valid every cycle, producer holds rejected requests
    wb_stall = 1'b1; chk_addr_a = 4'd8; chk_addr_b = 4'd0;
    alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'h100;
    aes_valid = 1'b0; aes_addr = 4'd12; aes_data = 32'hA5;
    for (int i = 0; i < 7; i++) begin
      aes_valid = (i == 3);
      tick(aa, ab);
      if (aa) begin alu_addr = alu_addr + 4'd1; alu_data = alu_data + 32'h1; end
      if (ab) aes_valid = 1'b0;
    end
    aes_valid = 1'b0;
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(aa, ab);
      if (aa) begin alu_addr = alu_addr + 4'd1; alu_data = alu_data + 32'h1; end
    end
    alu_valid = 1'b0;
    ticks(6);

    // Address 0 write is accepted but dropped
    chk_addr_a = 4'd0; chk_addr_b = 4'd0;
    aes_valid = 1'b1; aes_addr = 4'd0; aes_data = 32'hFFFFFFFF;
    tick(aa, ab);
    aes_valid = 1'b0;
    ticks(3);

    // Steady state, both producers valid every cycle
    chk_addr_a = 4'd1; chk_addr_b = 4'd2;
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h1000;
    aes_valid = 1'b1; aes_addr = 4'd2; aes_data = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      tick(aa, ab);
      if (aa) alu_data = alu_data + 32'h1;
      if (ab) aes_data = aes_data + 32'h1;
    end
    alu_valid = 1'b0; aes_valid = 1'b0;
    ticks(6);

    // Wrap-around with random stalls and traffic
    n_acc = 0;
    alu_valid = 1'b0; aes_valid = 1'b0;
    for (int i = 0; i < 300 && n_acc < 3 * FD + 1; i++) begin
      if (!alu_valid) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = 4'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      if (!aes_valid) begin
        aes_valid = ($urandom_range(0, 1) != 0);
        aes_addr  = 4'($urandom_range(0, 15));
        aes_data  = $urandom;
      end
      wb_stall   = ($urandom_range(0, 2) == 0);
      chk_addr_a = 4'($urandom_range(0, 15));
      chk_addr_b = 4'($urandom_range(0, 15));
      tick(aa, ab);
      if (aa) begin if (alu_addr != 0) n_acc++; alu_valid = 1'b0; end
      if (ab) begin if (aes_addr != 0) n_acc++; aes_valid = 1'b0; end
    end
    chk("wrap_progress", n_acc >= 3 * FD + 1, 1);
    alu_valid = 1'b0; aes_valid = 1'b0; wb_stall = 1'b0;
    ticks(6);

    // Reset mid-stream with three entries queued
    wb_stall = 1'b1; chk_addr_a = 4'd10; chk_addr_b = 4'd11;
    alu_valid = 1'b1; alu_addr = 4'd10; alu_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick(aa, ab);
      if (aa) alu_addr = alu_addr + 4'd1;
    end
    rst = 1'b1;
    tick(aa, ab);
    rst = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
    tick(aa, ab);
    alu_valid = 1'b1; alu_addr = 4'd10; alu_data = 32'h77;
    tick(aa, ab);
    alu_valid = 1'b0;
    ticks(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffered write-back stage sitting directly upstream of the register file's single write port. It accepts result writes from two producers, the scalar ALU and the multi-cycle AES round unit, through valid/ready handshakes. It queues them in order in a small FIFO and retires at most one per cycle onto the register file's `addressw`/`writeData`/`writeEn` port. It also exposes a combinational read-after-write hazard flag so decode can stall on registers with writes still in flight.

## Interface
- `DEPTH`, default 16: number of architectural registers. Address width is `AW = $clog2(DEPTH)`.
- `BITS`, default 32: data width.
- `FIFO_DEPTH`, default 4: queue entries, at least 2. Count width is `$clog2(FIFO_DEPTH+1)`.

Ports (clock and reset first):
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `alu_valid`  in  1  — ALU write request.
- `alu_addr`  in  AW  — ALU destination register.
- `alu_data`  in  BITS  — ALU result.
- `alu_ready`  out  1  — ALU request accepted this cycle when `alu_valid & alu_ready`.
- `aes_valid`  in  1  — AES unit write request.
- `aes_addr`  in  AW  — AES destination register.
- `aes_data`  in  BITS  — AES result word.
- `aes_ready`  out  1  — AES request accepted this cycle when `aes_valid & aes_ready`.
- `wb_stall`  in  1  — inhibits dequeue this cycle.
- `chk_addr_a`, `chk_addr_b`  in  AW  — source registers being decoded.
- `hazard`  out  1  — a pending write targets `chk_addr_a` or `chk_addr_b`.
- `addressw`  out  AW  — register file write address (registered).
- `writeData`  out  BITS  — register file write data (registered).
- `writeEn`  out  1  — register file write enable (registered).
- `count`  out  cnt width  — current FIFO occupancy.
- `idle`  out  1  — `count==0 & !writeEn`.

## Operation
Ready rules are combinational from registered `count` only. A dequeue in the same cycle does not free space.
- `alu_ready = count < FIFO_DEPTH`.
- `aes_ready = count < FIFO_DEPTH-1`. This guarantees room for a simultaneous ALU enqueue.

Enqueue:
- Every accepted request is enqueued at the tail, except requests to address 0, which are handshaken but dropped. Register 0 is hardwired zero.
- If both are accepted in the same cycle, the ALU entry is placed ahead of the AES entry.
- Up to 2 enqueues per cycle.

Dequeue:
- If `count>0` and `!wb_stall`, pop the head and load `{addressw, writeData}`, with `writeEn<=1`.
- Otherwise `writeEn<=0`. `addressw`/`writeData` hold their last values.

Occupancy and ordering:
- `count_next = count + enq_alu + enq_aes - deq`. Never exceeds `FIFO_DEPTH` and never goes negative.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Non-power-of-two depths must wrap correctly.
- Writes retire in strict acceptance order. Two queued writes to the same register retire in order, so the later one wins.

Hazard:
- `hazard` is 1 if any valid FIFO entry, or the output stage while `writeEn=1`, has an address equal to a nonzero `chk_addr_a` or `chk_addr_b`.
- Requests being accepted in the current cycle are not included.
- `chk_addr==0` never flags.

Reset:
- `count=0`, both pointers 0, `writeEn=0`, `addressw=0`, `writeData=0`.
- Queued entries are discarded, including when reset is applied mid-stream.
- Requests presented during reset are not accepted: `alu_ready=aes_ready=0` while `rst=1`.

## Timing
- Latency: a request accepted in cycle N into an empty queue with `wb_stall=0` is popped in cycle N+1. `writeEn=1` with its address/data in cycle N+2. The register file captures it at the end of N+2.
- Throughput: one retirement per cycle.
- Steady state with both producers valid every cycle from empty:
  - Cycles 0 and 1 accept both producers.
  - From cycle 2, `aes_ready=0` and `alu_ready=1`, and `count` holds at 3.
- Under `wb_stall=1`, `count` reaches `FIFO_DEPTH`. `alu_ready=0` at `count=FIFO_DEPTH`; `aes_ready=0` at `count>=FIFO_DEPTH-1`.
- A stall that is released in cycle M gives `writeEn=1` in cycle M+1.
- `hazard` for an entry drops in the cycle after its `writeEn=1` cycle.

## Test plan
- Single write: ALU write `addr=5`, `data=0xDEADBEEF` in cycle 0 → `writeEn=1`, `addressw=5`, `writeData=0xDEADBEEF` in cycle 2 only. `hazard` for `chk_addr_a=5` is high in cycles 1–2 and low in cycle 3.
- Simultaneous producers: ALU (3, 0x11) and AES (3, 0x22) in the same cycle → two consecutive writes to register 3, 0x11 then 0x22. `hazard(3)` is high until the 0x22 write retires.
- Full/backpressure: `wb_stall=1`, ALU valid every cycle:
  - `count` goes 1,2,3,4.
  - `aes_ready=0` from `count=3`; `alu_ready=0` at 4; extra requests are held by the producer, not lost.
  - Release the stall → four writes on consecutive cycles, in order.
- Address 0: AES write to register 0 with data 0xFFFFFFFF → handshake completes, `count` stays 0, no `writeEn` pulse, `hazard(0)=0`.
- Wrap-around: 3·`FIFO_DEPTH`+1 writes with random stalls, compared against a reference queue model → identical order and data, `count` never exceeds `FIFO_DEPTH`.
- Reset mid-operation: queue 3 entries, assert `rst` for 1 cycle → next cycle `count=0`, `writeEn=0`, `hazard=0`, `idle=1`. A new write afterwards retires normally with 2-cycle latency.
